// File: rtl/nes_line_fetch.sv
// nes_line_fetch: 2x-upscaled NES pixel source for the VGA controller.
// Ping-pong line buffers are filled one source line ahead over a read/grant/valid port.
module nes_line_fetch #(
  parameter int          LATENCY    = 4,
  parameter int          H_OFFSET   = 64,
  parameter logic [29:0] BORDER_RGB = 30'h0,
  parameter int          SRC_W      = 256,
  parameter int          SRC_H      = 240
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [10:0] iX,
  input  logic [10:0] iY,
  input  logic        iRequest,
  input  logic        iVS,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic [15:0] oMemAddr,
  output logic        oMemRd,
  input  logic        iMemGnt,
  input  logic        iMemValid,
  input  logic [5:0]  iMemData,
  input  logic        iPalWe,
  input  logic [5:0]  iPalAddr,
  input  logic [29:0] iPalData,
  output logic        oFetchErr
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  localparam logic [10:0] X_LO    = 11'(H_OFFSET);
  localparam logic [10:0] X_HI    = 11'(H_OFFSET + 2 * SRC_W);
  localparam logic [9:0]  S_LAST  = 10'(SRC_H - 1);
  localparam logic [8:0]  N_WORDS = 9'(SRC_W);
  localparam int          DEPTH   = LATENCY - 3;
  state_t      state_q, state_d;
  logic [10:0] x1_q, x1_d, y1_q, y1_d;
  logic        req1_q, req1_d, vs1_q, vs1_d, req_p_q, req_p_d, vs_p_q, vs_p_d;
  logic [5:0]  lb_rd_q, lb_rd_d;
  logic        req2_q, req2_d, brd2_q, brd2_d, req3_q, req3_d, brd3_q, brd3_d;
  logic [29:0] pal_rd_q, pal_rd_d;
  logic [29:0] rgb_q [DEPTH];
  logic [29:0] rgb_d [DEPTH];
  logic [7:0]  line_q, line_d;
  logic [8:0]  issue_cnt_q, issue_cnt_d, recv_cnt_q, recv_cnt_d;
  logic        err_q, err_d;
  logic        vs_trig, rq_trig, trig, start, lb_we;
  logic [8:0]  lb_wa;
  logic [5:0]  lb [2*SRC_W];
  logic [29:0] pal [64];
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state_q     <= IDLE;
      x1_q        <= '0;
      y1_q        <= '0;
      req1_q      <= 1'b0;
      vs1_q       <= 1'b1;
      req_p_q     <= 1'b0;
      vs_p_q      <= 1'b1;
      lb_rd_q     <= '0;
      req2_q      <= 1'b0;
      brd2_q      <= 1'b0;
      req3_q      <= 1'b0;
      brd3_q      <= 1'b0;
      pal_rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) rgb_q[i] <= '0;
      line_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      req1_q      <= req1_d;
      vs1_q       <= vs1_d;
      req_p_q     <= req_p_d;
      vs_p_q      <= vs_p_d;
      lb_rd_q     <= lb_rd_d;
      req2_q      <= req2_d;
      brd2_q      <= brd2_d;
      req3_q      <= req3_d;
      brd3_q      <= brd3_d;
      pal_rd_q    <= pal_rd_d;
      for (int i = 0; i < DEPTH; i++) rgb_q[i] <= rgb_d[i];
      line_q      <= line_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      err_q       <= err_d;
    end
  // Palette read-before-write gives old data when the same entry is written this cycle.
  always_ff @(posedge iCLK) begin
    if (iPalWe) pal[iPalAddr] <= iPalData;
    if (lb_we) lb[lb_wa] <= iMemData;
  end
  always_comb begin
    x1_d        = iX;
    y1_d        = iY;
    req1_d      = iRequest;
    vs1_d       = iVS;
    req_p_d     = req1_q;
    vs_p_d      = vs1_q;
    req2_d      = req1_q;
    brd2_d      = (x1_q < X_LO) | (x1_q >= X_HI);
    lb_rd_d     = lb[{y1_q[1], 8'((x1_q - X_LO) >> 1)}];
    req3_d      = req2_q;
    brd3_d      = brd2_q;
    pal_rd_d    = pal[lb_rd_q];
    rgb_d[0]    = !req3_q ? '0 : brd3_q ? BORDER_RGB : pal_rd_q;
    for (int i = 1; i < DEPTH; i++) rgb_d[i] = rgb_q[i-1];
    vs_trig     = vs_p_q & ~vs1_q;
    rq_trig     = req1_q & ~req_p_q & ~y1_q[0] & (y1_q[10:1] < S_LAST);
    trig        = vs_trig | rq_trig;
    start       = (state_q == IDLE) & trig;
    issue_cnt_d = start ? '0 : issue_cnt_q + 9'((state_q == ISSUE) & iMemGnt);
    recv_cnt_d  = start ? '0 : recv_cnt_q + 9'(lb_we);
    line_d      = start ? (vs_trig ? 8'd0 : 8'(y1_q[10:1] + 10'd1)) : line_q;
    err_d       = err_q | (trig & (state_q != IDLE));
    state_d     = state_q == IDLE  ? (trig ? ISSUE : IDLE) :
                  state_q == ISSUE ? (issue_cnt_d == N_WORDS ? DRAIN : ISSUE) :
                                     (recv_cnt_d == N_WORDS ? IDLE : DRAIN);
  end
  always_comb begin
    oMemRd                 = state_q == ISSUE;
    oMemAddr               = {line_q, issue_cnt_q[7:0]};
    lb_we                  = (state_q != IDLE) & iMemValid;
    lb_wa                  = {line_q[0], recv_cnt_q[7:0]};
    {oRed, oGreen, oBlue}  = rgb_q[DEPTH-1];
    oFetchErr              = err_q;
  end
endmodule

// File: tb/tb_nes_line_fetch.sv
// tb_nes_line_fetch: pixels are scored against a frame/palette model through a
// queue popped four clocks after each request; memory responder checks addresses.
module tb_nes_line_fetch;
  localparam logic [29:0] BRD = {10'h155, 10'h2AA, 10'h0F0};
  localparam logic [29:0] MAG = {10'h3FF, 10'h000, 10'h3FF};
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic        req = 1'b0, vs = 1'b1;
  logic        gnt, mvalid;
  logic [5:0]  mdata;
  logic        pal_we = 1'b0;
  logic [5:0]  pal_a = '0;
  logic [29:0] pal_d = '0;
  logic [9:0]  r, g, b;
  logic [15:0] mem_addr;
  logic        mem_rd, err;
  int total = 0, bad = 0;
  int gcnt = 0, vcnt = 0, rdcyc = 0, exp_addr = 0, lat_fix = 1, dmode = 0, five_below = -1;
  int cyc = 0, last_due = 0;
  bit stall = 1'b0, mark = 1'b0;
  logic [3:0]  chk_sr = '0;
  logic [29:0] sb[$];
  typedef struct {int due; logic [5:0] d;} rsp_t;
  rsp_t pq[$];

  nes_line_fetch #(.BORDER_RGB(BRD)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iX(x), .iY(y), .iRequest(req), .iVS(vs),
    .oRed(r), .oGreen(g), .oBlue(b), .oMemAddr(mem_addr), .oMemRd(mem_rd),
    .iMemGnt(gnt), .iMemValid(mvalid), .iMemData(mdata),
    .iPalWe(pal_we), .iPalAddr(pal_a), .iPalData(pal_d), .oFetchErr(err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [5:0] hsh(input int a);
    logic [15:0] v = 16'(a);
    return v[5:0] ^ v[13:8];
  endfunction

  function automatic logic [29:0] pm(input int i);
    return i == 5 ? MAG : {10'(i * 37 + 11), 10'(i * 5 + 1), 10'(1000 - i * 9)};
  endfunction

  function automatic logic [29:0] exp_px(input bit rq, input int xx, input int yy);
    int sx = (xx - 64) >> 1;
    int s = yy >> 1;
    if (!rq) return '0;
    if (xx < 64 || xx >= 576) return BRD;
    if (s == 0 && sx < five_below) return MAG;
    return pm(int'(hsh(s * 256 + sx)));
  endfunction

  // Memory responder: grant decided at the negedge, in-order data after the chosen latency.
  initial begin
    int l, due;
    gnt = 1'b0; mvalid = 1'b0; mdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_rd) rdcyc++;
      gnt = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (gnt && mem_rd) begin
        chk("addr", 32'(mem_addr), 32'(exp_addr));
        exp_addr++;
        gcnt++;
        l = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 6));
        due = cyc + l;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pq.push_back('{due, dmode == 2 ? 6'd5 : hsh(int'(mem_addr))});
      end
      mvalid = 1'b0;
      if (pq.size() != 0 && pq[0].due == cyc) begin
        mvalid = 1'b1;
        mdata = pq[0].d;
        vcnt++;
        void'(pq.pop_front());
      end
    end
  end

  always @(posedge clk) chk_sr <= {chk_sr[2:0], mark};
  always @(negedge clk)
    if (chk_sr[3]) begin
      if (sb.size() == 0) chk("pixel_missing", 32'd1, 32'd0);
      else chk("pixel", 32'({r, g, b}), 32'(sb.pop_front()));
    end

  task automatic drive(input bit rq, input int xx, input int yy, input bit c, input logic [29:0] e);
    @(negedge clk);
    req = rq; x = 11'(xx); y = 11'(yy); mark = c;
    if (c) sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mark = 1'b0; req = 1'b0;
    end
  endtask

  task automatic row(input int yy, input bit c);
    for (int xx = 0; xx < 800; xx++)
      drive(xx < 640, xx < 640 ? xx : 0, yy, c, exp_px(xx < 640, xx, yy));
    idle(1);
  endtask

  task automatic vs_fall();
    @(negedge clk) vs = 1'b0;
    repeat (3) @(negedge clk);
    vs = 1'b1;
  endtask

  task automatic wait_fetch(input string n);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (gcnt >= 256 && pq.size() == 0 && !mem_rd) break;
    end
    chk({n, "_timeout"}, 32'(i < 5000), 32'd1);
    chk({n, "_grants"}, 32'(gcnt), 32'd256);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int i;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      x = 11'($urandom); y = 11'($urandom); req = 1'($urandom); vs = 1'($urandom);
      #1;
      chk("rst_rgb", 32'({r, g, b}), 32'd0);
      chk("rst_rd", 32'(mem_rd), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end
    @(negedge clk) begin x = '0; y = '0; req = 1'b0; vs = 1'b1; end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      pal_we = 1'b1; pal_a = 6'(k); pal_d = pm(k);
    end
    @(negedge clk) pal_we = 1'b0;

    dmode = 2; exp_addr = 0; gcnt = 0;
    vs_fall();
    wait_fetch("lat_fill");
    exp_addr = 256; gcnt = 0;
    drive(1, 100, 0, 1, MAG);
    drive(1, 10, 0, 1, BRD);
    drive(1, 576, 0, 1, BRD);
    drive(1, 575, 0, 1, MAG);
    drive(1, 63, 0, 1, BRD);
    drive(1, 64, 0, 1, MAG);
    drive(0, 100, 0, 1, 30'h0);
    idle(8);
    wait_fetch("lat_line1");

    dmode = 1; stall = 1'b1; lat_fix = 3; exp_addr = 0; gcnt = 0;
    vs_fall();
    wait_fetch("pre_line0");
    lat_fix = 0;
    for (int yy = 0; yy < 8; yy++) begin
      if (yy % 2 == 0) begin exp_addr = (yy / 2 + 1) * 256; gcnt = 0; end
      row(yy, 1'b1);
      if (yy % 2 == 1) wait_fetch("frame_line");
    end
    chk("frame_err", 32'(err), 32'd0);
    exp_addr = 239 * 256; gcnt = 0;
    row(476, 1'b0);
    wait_fetch("frame_l239");
    row(477, 1'b0);
    gcnt = 0; rdcyc = 0;
    row(478, 1'b1);
    row(479, 1'b1);
    chk("last_no_grant", 32'(gcnt), 32'd0);
    chk("last_no_rd", 32'(rdcyc), 32'd0);
    chk("last_err", 32'(err), 32'd0);

    exp_addr = 0; gcnt = 0;
    vs_fall();
    repeat (46) @(negedge clk);
    vs_fall();
    repeat (5) @(negedge clk);
    chk("ovr_err", 32'(err), 32'd1);
    wait_fetch("ovr_first");
    repeat (100) @(negedge clk);
    chk("ovr_sticky", 32'(err), 32'd1);
    exp_addr = 256; gcnt = 0;
    row(0, 1'b1);
    wait_fetch("ovr_line1");

    dmode = 2; lat_fix = 6; exp_addr = 0; gcnt = 0; vcnt = 0;
    vs_fall();
    for (i = 0; i < 2000 && gcnt < 100; i++) @(posedge clk);
    chk("abort_wait", 32'(gcnt >= 100), 32'd1);
    #1 rst_n = 1'b0;
    five_below = vcnt;
    #1 chk("abort_rd_drop", 32'(mem_rd), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_err_clr", 32'(err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (i = 0; i < 100 && pq.size() != 0; i++) @(negedge clk);
    chk("abort_drain", 32'(pq.size()), 32'd0);
    dmode = 1; exp_addr = 256; gcnt = 0;
    row(0, 1'b1);
    wait_fetch("abort_line1");
    five_below = -1;
    exp_addr = 0; gcnt = 0;
    vs_fall();
    wait_fetch("restart");
    exp_addr = 256; gcnt = 0;
    row(0, 1'b1);
    wait_fetch("restart_line1");
    idle(10);
    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
